// File: rtl/ripemd_padder_if.sv
// Byte-stream input and padded-block output of the RIPEMD-160 padder.
// The producer/consumer side is the master; the padder itself is the slave.
interface ripemd_padder_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] block;
  logic         o_valid;
  logic         o_ready;
  logic         o_first;
  logic         o_last;

  modport master (
    output s_data, s_valid, s_last, o_ready,
    input  s_ready, block, o_valid, o_first, o_last
  );

  modport slave (
    input  s_data, s_valid, s_last, o_ready,
    output s_ready, block, o_valid, o_first, o_last
  );
endinterface

// File: rtl/ripemd_padder.sv
// RIPEMD-160 message padder: packs a byte stream into 512-bit blocks with the
// 0x80 marker, zero fill and 64-bit little-endian bit length (MD strengthening).
module ripemd_padder #(
  parameter int LEN_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  ripemd_padder_if.slave  bus
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]       state;
  logic [5:0]       ptr;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_nxt;
  logic [511:0]     buffer;
  logic             tail;
  logic             mark_done;
  logic             first_q;
  logic             last_q;
  logic             accept;
  logic [6:0]       cnt;

  // Length field is always 64 bits wide regardless of the counter width.
  function automatic logic [63:0] len_field(input logic [LEN_W-1:0] l);
    logic [63:0] r;
    r = '0;
    r[LEN_W-1:0] = l;
    return r;
  endfunction

  assign accept  = bus.s_valid && bus.s_ready;
  assign len_nxt = len + LEN_W'(8);
  assign cnt     = {1'b0, ptr} + 7'd1;

  assign bus.s_ready = (state == FILL) && rst_n;
  assign bus.o_valid = (state == EMIT);
  assign bus.block   = buffer;
  assign bus.o_first = first_q;
  assign bus.o_last  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      ptr       <= '0;
      len       <= '0;
      buffer    <= '0;
      tail      <= 1'b0;
      mark_done <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            buffer[{ptr, 3'b000} +: 8] <= bus.s_data;
            ptr <= ptr + 6'd1;
            len <= len_nxt;
            if (bus.s_last) begin
              state <= EMIT;
              if (cnt <= 7'd55) begin
                // Marker and length both fit behind the last byte.
                buffer[{cnt[5:0], 3'b000} +: 8] <= 8'h80;
                buffer[511:448] <= len_field(len_nxt);
                last_q <= 1'b1;
                tail   <= 1'b0;
              end else if (cnt <= 7'd63) begin
                buffer[{cnt[5:0], 3'b000} +: 8] <= 8'h80;
                last_q    <= 1'b0;
                tail      <= 1'b1;
                mark_done <= 1'b1;
              end else begin
                last_q    <= 1'b0;
                tail      <= 1'b1;
                mark_done <= 1'b0;
              end
            end else if (ptr == 6'd63) begin
              state  <= EMIT;
              last_q <= 1'b0;
              tail   <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (bus.o_ready) begin
            // Clearing here makes the zero fill of the next block implicit.
            buffer  <= '0;
            ptr     <= '0;
            first_q <= last_q;
            if (last_q) begin
              len <= '0;
            end
            state <= tail ? TAIL : FILL;
          end
        end
        TAIL: begin
          if (!mark_done) begin
            buffer[7:0] <= 8'h80;
          end
          buffer[511:448] <= len_field(len);
          last_q <= 1'b1;
          tail   <= 1'b0;
          state  <= EMIT;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ripemd_padder.sv
// Randomised bench for ripemd_padder: byte streams with random valid gaps and
// output backpressure, checked against a padding model built from byte queues.
module tb_ripemd_padder;

  typedef logic [7:0] u8_t;
  typedef struct {
    logic [511:0] blk;
    bit           f;
    bit           l;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  logic [511:0] last_blk;
  logic [511:0] abc_ref;

  ripemd_padder_if bus ();

  ripemd_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
  function automatic void build(input u8_t m[$]);
    u8_t p[$];
    logic [63:0] bl;
    exp_t e;
    int nb;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int k = 0; k < 64; k++) e.blk[8*k +: 8] = p[64*b + k];
      e.f = (b == 0);
      e.l = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic run_msg(input u8_t m[$], input bit bp);
    int idx;
    int cyc;
    int wait_cnt;
    int limit;
    bit hold;
    logic [511:0] hb;
    logic hf;
    logic hl;
    exp_t e;
    build(m);
    idx = 0; cyc = 0; wait_cnt = 0; hold = 0; hb = '0; hf = 0; hl = 0;
    limit = 40 * m.size() + 200;
    while ((idx < m.size() || exp_q.size() != 0) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", 512'(bus.o_valid), 512'(1));
        chk("hold_blk", bus.block, hb);
        chk("hold_first", 512'(bus.o_first), 512'(hf));
        chk("hold_last", 512'(bus.o_last), 512'(hl));
      end
      if (bus.o_valid) chk("sready_lo", 512'(bus.s_ready), 512'(0));
      if (idx < m.size() && $urandom_range(3) != 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = m[idx];
        bus.s_last  = (idx == m.size() - 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom);
      end
      if (bp) bus.o_ready = bus.o_valid && (wait_cnt >= 5);
      else    bus.o_ready = 1'($urandom_range(1));
      if (bus.o_valid) begin
        if (bus.o_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_blk", 512'(1), 512'(0));
          end else begin
            e = exp_q.pop_front();
            chk("blk", bus.block, e.blk);
            chk("first", 512'(bus.o_first), 512'(e.f));
            chk("last", 512'(bus.o_last), 512'(e.l));
          end
          last_blk = bus.block;
          wait_cnt = 0;
          hold = 0;
        end else begin
          wait_cnt++;
          hold = 1;
          hb = bus.block;
          hf = bus.o_first;
          hl = bus.o_last;
        end
      end else begin
        hold = 0;
      end
      if (bus.s_valid && bus.s_ready) idx++;
    end
    chk("msg_done", 512'((idx == m.size()) && (exp_q.size() == 0)), 512'(1));
    exp_q.delete();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.o_ready = 1'b0;
  endtask

  function automatic void fill(output u8_t m[$], input int n, input int mode);
    m = {};
    for (int i = 0; i < n; i++) begin
      if (mode == 0)      m.push_back(8'h41);
      else if (mode == 1) m.push_back(8'h00);
      else                m.push_back(8'($urandom));
    end
  endfunction

  initial begin
    u8_t m[$];
    int idx;
    n_vec = 0;
    n_err = 0;
    last_blk = '0;
    abc_ref = '0;
    abc_ref[31:0] = 32'h80636261;
    abc_ref[511:448] = 64'h18;
    bus.s_data = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.o_ready = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sready", 512'(bus.s_ready), 512'(0));
    chk("rst_ovalid", 512'(bus.o_valid), 512'(0));
    chk("rst_first", 512'(bus.o_first), 512'(1));
    chk("rst_last", 512'(bus.o_last), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sready", 512'(bus.s_ready), 512'(1));

    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 0);
    chk("abc_blk", last_blk, abc_ref);

    fill(m, 55, 0);  run_msg(m, 1);
    fill(m, 56, 0);  run_msg(m, 1);
    fill(m, 64, 1);  run_msg(m, 0);
    fill(m, 63, 2);  run_msg(m, 1);
    fill(m, 119, 2); run_msg(m, 0);
    fill(m, 120, 2); run_msg(m, 1);
    fill(m, 128, 2); run_msg(m, 0);
    fill(m, 1, 2);   run_msg(m, 1);
    fill(m, 10, 2);  run_msg(m, 1);

    for (int r = 0; r < 12; r++) begin
      fill(m, $urandom_range(140, 1), 2);
      run_msg(m, 1'($urandom_range(1)));
    end

    // Abort a message part-way through with reset, then send "abc".
    fill(m, 30, 2);
    idx = 0;
    while (idx < 30) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = m[idx];
      bus.s_last  = 1'b0;
      if (bus.s_ready) idx++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_sready", 512'(bus.s_ready), 512'(0));
    chk("abort_ovalid", 512'(bus.o_valid), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 0);
    chk("abc_after_rst", last_blk, abc_ref);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
